// File: rtl/elastic_pipeline_pkg.sv
// elastic_pipeline_pkg: shared sizing and handshake helpers for elastic_pipeline
package elastic_pipeline_pkg;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// elastic_stage: one valid bit plus a data register that loads only on valid captures
module elastic_stage
    import elastic_pipeline_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              v,
    output logic [DATA_W-1:0] d
);

    always_ff @(posedge clk) begin
        if (reset) begin
            v <= 1'b0;
            d <= '0;
        end else begin
            v <= flush ? 1'b0 : (load ? src_valid : v);
            if (fire(load, src_valid) && !flush) d <= src_data;
        end
    end

endmodule

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: DEPTH-stage valid/ready register pipeline that collapses bubbles on stall.
// Define ELASTIC_PIPELINE_OCC_EN to add a registered occupancy output.
module elastic_pipeline
    import elastic_pipeline_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef ELASTIC_PIPELINE_OCC_EN
   ,output logic [occ_w(DEPTH)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0]             v, load, src_v;
    logic [DEPTH-1:0][DATA_W-1:0] d, src_d;

    // A stage may load when it or any stage downstream of it has room.
    always_comb begin
        load[DEPTH-1] = ~v[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) load[i] = ~v[i] | load[i+1];
    end

    assign in_ready  = load[0] & ~flush & ~reset;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign src_v[i] = fire(in_valid, in_ready);
            assign src_d[i] = in_data;
        end else begin : g_next
            assign src_v[i] = v[i-1];
            assign src_d[i] = d[i-1];
        end
        elastic_stage #(.DATA_W(DATA_W)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .load      (load[i]),
            .src_valid (src_v[i]),
            .src_data  (src_d[i]),
            .v         (v[i]),
            .d         (d[i])
        );
    end

`ifdef ELASTIC_PIPELINE_OCC_EN
    localparam int OCC_W = occ_w(DEPTH);
    logic in_fire, out_fire;
    assign in_fire  = fire(in_valid, in_ready);
    assign out_fire = fire(out_valid, out_ready);
    always_ff @(posedge clk) begin
        if (reset || flush) occupancy <= '0;
        else if (in_fire && !out_fire) occupancy <= occupancy + OCC_W'(1);
        else if (out_fire && !in_fire) occupancy <= occupancy - OCC_W'(1);
    end
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
// tb_elastic_pipeline: randomized checks of elastic_pipeline against a word/position queue model.
module tb_elastic_pipeline;

    localparam int D = 5;
    localparam int W = 128;

    logic         clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic         reset1 = 1'b1, flush1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [7:0]   in_data1 = 8'h00;
    logic         in_ready1, out_valid1;
    logic [7:0]   out_data1;
`ifdef ELASTIC_PIPELINE_OCC_EN
    logic [2:0]   occupancy;
    logic [0:0]   occupancy1;
`endif

    always #5 clk = ~clk;

    elastic_pipeline #(.DATA_W(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef ELASTIC_PIPELINE_OCC_EN
       ,.occupancy(occupancy)
`endif
    );

    elastic_pipeline #(.DATA_W(8), .DEPTH(1)) dut1 (
        .clk(clk), .reset(reset1), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
`ifdef ELASTIC_PIPELINE_OCC_EN
       ,.occupancy(occupancy1)
`endif
    );

    int errors = 0, checks = 0;

    // Model: held words in arrival order with their stage positions, plus the last word each stage captured.
    logic [W-1:0] qd[$];
    int           qp[$];
    logic [W-1:0] last_d [D];
    logic         exp_ov, exp_rdy;
    logic [W-1:0] exp_od;

    task automatic predict();
        exp_rdy = !reset && !flush && (qd.size() < D || out_ready);
        exp_ov  = (qp.size() > 0) ? (qp[0] == D - 1) : 1'b0;
        exp_od  = exp_ov ? qd[0] : '0;
    endtask

    task automatic advance();
        logic fin, fout;
        fin  = exp_rdy && in_valid;
        fout = exp_ov && out_ready;
        if (reset) begin
            qd.delete(); qp.delete();
            foreach (last_d[i]) last_d[i] = '0;
            return;
        end
        if (flush) begin
            qd.delete(); qp.delete();
            return;
        end
        // A word moves when the consumer takes a word or a free slot exists somewhere ahead of it.
        foreach (qp[j]) if (out_ready || (D - 1 - qp[j]) > j) qp[j]++;
        if (fout) begin
            void'(qd.pop_front());
            void'(qp.pop_front());
        end
        foreach (qp[j]) last_d[qp[j]] = qd[j];
        if (fin) begin
            qd.push_back(in_data);
            qp.push_back(0);
            last_d[0] = in_data;
        end
    endtask

    task automatic tick();
        advance();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 128'hDEAD; out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            predict();
            checks++;
            if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset: got ov=%b rdy=%b od=%h, want ov=0 rdy=0 od=0", out_valid, in_ready, out_data);
            end
            tick();
        end
        reset = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_streaming();
        int first_in = -1, first_out = -1;
        out_ready = 1'b1;
        for (int n = 0; n < 16 + D + 2; n++) begin
            in_valid = (n < 16);
            in_data  = W'(n + 1);
            @(negedge clk);
            predict();
            if (first_in < 0 && in_valid && in_ready) first_in = n;
            if (first_out < 0 && out_valid) first_out = n;
            checks++;
            if (out_valid !== exp_ov || (exp_ov && out_data !== exp_od) || in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL stream[%0d]: got ov=%b rdy=%b od=%h, want ov=%b rdy=%b od=%h", n, out_valid, in_ready, out_data, exp_ov, exp_rdy, exp_od);
            end
            tick();
        end
        checks++;
        if (first_out - first_in !== D) begin
            errors++;
            $display("FAIL latency: got %0d cycles, want %0d", first_out - first_in, D);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall_fill();
        logic [D-1:0] ev;
        out_ready = 1'b0;
        for (int n = 0; n < 10; n++) begin
            in_valid = (n < 3 || n > 5);
            in_data  = rnd();
            @(negedge clk);
            predict();
            checks++;
            if (out_valid !== exp_ov || (exp_ov && out_data !== exp_od) || in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL stall[%0d]: got ov=%b rdy=%b od=%h, want ov=%b rdy=%b od=%h", n, out_valid, in_ready, out_data, exp_ov, exp_rdy, exp_od);
            end
            ev = '0;
            foreach (qp[j]) ev[qp[j]] = 1'b1;
            checks++;
            if (dut.v !== ev) begin
                errors++;
                $display("FAIL stall_compact[%0d]: got v=%b, want %b", n, dut.v, ev);
            end
`ifdef ELASTIC_PIPELINE_OCC_EN
            checks++;
            if (occupancy !== 3'(qd.size())) begin
                errors++;
                $display("FAIL stall_occ[%0d]: got %0d, want %0d", n, occupancy, qd.size());
            end
`endif
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_pass();
        out_ready = 1'b1;
        for (int n = 0; n < 10 + D + 1; n++) begin
            in_valid = (n < 10);
            in_data  = rnd();
            @(negedge clk);
            predict();
            checks++;
            if (out_valid !== exp_ov || (exp_ov && out_data !== exp_od) || in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL full[%0d]: got ov=%b rdy=%b od=%h, want ov=%b rdy=%b od=%h", n, out_valid, in_ready, out_data, exp_ov, exp_rdy, exp_od);
            end
`ifdef ELASTIC_PIPELINE_OCC_EN
            checks++;
            if (occupancy !== 3'(qd.size())) begin
                errors++;
                $display("FAIL full_occ[%0d]: got %0d, want %0d", n, occupancy, qd.size());
            end
`endif
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_bubbles();
        out_ready = 1'b1;
        for (int n = 0; n < 14 + D; n++) begin
            in_valid = (n < 14) && (n % 2 == 0);
            in_data  = rnd();
            @(negedge clk);
            predict();
            checks++;
            if (out_valid !== exp_ov || (exp_ov && out_data !== exp_od) || in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL bubble[%0d]: got ov=%b rdy=%b od=%h, want ov=%b rdy=%b od=%h", n, out_valid, in_ready, out_data, exp_ov, exp_rdy, exp_od);
            end
            for (int i = 0; i < D; i++) begin
                checks++;
                if (dut.d[i] !== last_d[i]) begin
                    errors++;
                    $display("FAIL bubble_hold[%0d] stage %0d: got d=%h, want %h", n, i, dut.d[i], last_d[i]);
                end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        for (int n = 0; n < 6 + D + 1; n++) begin
            flush     = (n == 3);
            out_ready = (n >= 5);
            in_valid  = (n < 4 || n == 5);
            in_data   = (n == 5) ? W'(8'hAB) : rnd();
            @(negedge clk);
            predict();
            checks++;
            if (out_valid !== exp_ov || (exp_ov && out_data !== exp_od) || in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL flush[%0d]: got ov=%b rdy=%b od=%h, want ov=%b rdy=%b od=%h", n, out_valid, in_ready, out_data, exp_ov, exp_rdy, exp_od);
            end
`ifdef ELASTIC_PIPELINE_OCC_EN
            checks++;
            if (occupancy !== 3'(qd.size())) begin
                errors++;
                $display("FAIL flush_occ[%0d]: got %0d, want %0d", n, occupancy, qd.size());
            end
`endif
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(49) == 0);
            in_data   = rnd();
            @(negedge clk);
            predict();
            checks++;
            if (out_valid !== exp_ov || (exp_ov && out_data !== exp_od) || in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL random[%0d]: got ov=%b rdy=%b od=%h, want ov=%b rdy=%b od=%h", n, out_valid, in_ready, out_data, exp_ov, exp_rdy, exp_od);
            end
            for (int i = 0; i < D; i++) begin
                checks++;
                if (dut.d[i] !== last_d[i]) begin
                    errors++;
                    $display("FAIL random_hold[%0d] stage %0d: got d=%h, want %h", n, i, dut.d[i], last_d[i]);
                end
            end
`ifdef ELASTIC_PIPELINE_OCC_EN
            checks++;
            if (occupancy !== 3'(qd.size())) begin
                errors++;
                $display("FAIL random_occ[%0d]: got %0d, want %0d", n, occupancy, qd.size());
            end
`endif
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 20; n++) begin
            reset     = (n == 10 || n == 11);
            in_valid  = (n >= 6 && n < 12) || (n >= 12 && n < 15);
            out_ready = (n < 6 || n >= 12);
            in_data   = rnd();
            @(negedge clk);
            predict();
            checks++;
            if (out_valid !== exp_ov || (exp_ov && out_data !== exp_od) || in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got ov=%b rdy=%b od=%h, want ov=%b rdy=%b od=%h", n, out_valid, in_ready, out_data, exp_ov, exp_rdy, exp_od);
            end
            if (n == 11) begin
                checks++;
                if (out_data !== '0) begin
                    errors++;
                    $display("FAIL reset_mid_data: got od=%h, want 0", out_data);
                end
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    bit         r_t   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bit         iv_t  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit         or_t  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] id_t  [7] = '{8'h5A, 8'h33, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
    bit         rdy_t [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bit         ov_t  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] od_t  [7] = '{8'h00, 8'h5A, 8'h5A, 8'h33, 8'h33, 8'h00, 8'h00};
    bit         occ_t [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    task automatic test_depth1();
        for (int n = 0; n < 7; n++) begin
            reset1 = r_t[n]; in_valid1 = iv_t[n]; out_ready1 = or_t[n]; in_data1 = id_t[n];
            @(negedge clk);
            checks++;
            if (in_ready1 !== rdy_t[n] || out_valid1 !== ov_t[n] || out_data1 !== od_t[n]) begin
                errors++;
                $display("FAIL depth1[%0d]: got rdy=%b ov=%b od=%h, want rdy=%b ov=%b od=%h", n, in_ready1, out_valid1, out_data1, rdy_t[n], ov_t[n], od_t[n]);
            end
`ifdef ELASTIC_PIPELINE_OCC_EN
            checks++;
            if (occupancy1 !== occ_t[n]) begin
                errors++;
                $display("FAIL depth1_occ[%0d]: got %0d, want %0d", n, occupancy1, occ_t[n]);
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_stall_fill();
        test_full_pass();
        test_bubbles();
        test_flush();
        test_random();
        test_reset_mid();
        test_depth1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
